// File: rtl/fifo_req_sched.sv
// Round-robin bounded-burst write arbiter and read sequencer for the shared request FIFO.
// Latency: zero-cycle grant and pop. Backpressure: no grant at full, no pop at empty or when out_ready=0.
module fifo_req_sched #(
    parameter int WIDTH    = 21,
    parameter int DEPTH    = 32,
    parameter int ADDWIDTH = 5,
    parameter int NREQ     = 4,
    parameter int BURST    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  fifo_write,
    output logic [WIDTH-1:0]      fifo_dataIn,
    output logic                  fifo_read,
    input  logic [WIDTH-1:0]      fifo_dataOut,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
    output logic [2:0]            grant_id,
    output logic [ADDWIDTH:0]     count,
    output logic                  flag_err
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    typedef struct packed {
        state_t     state;
        logic [2:0] owner;
        logic [3:0] beats;
        logic [2:0] rr_ptr;
        logic [2:0] grant_id;
    } sched_t;

    localparam logic [ADDWIDTH:0] FULL_CNT  = (ADDWIDTH+1)'(DEPTH);
    localparam logic [3:0]        BURST_MAX = 4'(BURST);
    localparam logic [3:0]        NREQ_L    = 4'(NREQ);
    localparam logic [2:0]        LAST_IDX  = 3'(NREQ - 1);

    sched_t            cur;
    sched_t            nxt;
    logic [ADDWIDTH:0] count_q;
    logic [ADDWIDTH:0] count_d;
    logic              flag_q;
    logic              space;
    logic              lock;
    logic              found;
    logic [2:0]        winner;
    logic [3:0]        cand;
    logic              flag_mismatch;

    // Circular search for the first valid requester starting at rr_ptr.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, cur.rr_ptr} + 4'(k);
            if (cand >= NREQ_L) begin
                cand = cand - NREQ_L;
            end
            if (!found && req_valid[cand[2:0]]) begin
                found  = 1'b1;
                winner = cand[2:0];
            end
        end
    end

    always_comb begin
        nxt       = cur;
        req_ready = '0;
        space     = (count_q != FULL_CNT);
        lock      = (cur.state == ST_BURST) && req_valid[cur.owner] && (cur.beats < BURST_MAX);
        if (lock) begin
            // A locked owner stalled by a full FIFO keeps the port; nobody else gets in.
            if (space) begin
                req_ready[cur.owner] = 1'b1;
                nxt.beats            = cur.beats + 4'd1;
            end
        end else if (space && found) begin
            req_ready[winner] = 1'b1;
            nxt.state         = ST_BURST;
            nxt.owner         = winner;
            nxt.beats         = 4'd1;
            nxt.rr_ptr        = (winner == LAST_IDX) ? 3'd0 : winner + 3'd1;
            nxt.grant_id      = winner;
        end else begin
            nxt.state = ST_IDLE;
        end
        if (!reset) begin
            req_ready = '0;
        end
    end

    always_comb begin
        fifo_dataIn = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                fifo_dataIn = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign fifo_write = |(req_ready & req_valid);

    // Reads only see words already counted: no read-through of a same-cycle write.
    assign out_valid = reset && (count_q != '0);
    assign fifo_read = out_valid && out_ready;
    assign out_data  = fifo_dataOut;

    assign count_d = count_q + (ADDWIDTH+1)'(fifo_write) - (ADDWIDTH+1)'(fifo_read);

    assign flag_mismatch = (fifo_full != (count_q == FULL_CNT)) ||
                           (fifo_empty != (count_q == '0));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur     <= '{state: ST_IDLE, owner: '0, beats: '0, rr_ptr: '0, grant_id: '0};
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            cur     <= nxt;
            count_q <= count_d;
            if (flag_mismatch) begin
                flag_q <= 1'b1;
            end
        end
    end

    assign grant_id = cur.grant_id;
    assign count    = count_q;
    assign flag_err = flag_q;

endmodule

// File: tb/tb_fifo_req_sched.sv
// Bench for fifo_req_sched: behavioural FIFO, queue-based reference model, directed and random phases.
module tb_fifo_req_sched;

    localparam int W  = 21;
    localparam int D  = 32;
    localparam int NR = 4;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR*W-1:0] req_data = '0;
    logic [NR-1:0] req_ready;
    logic          fifo_write;
    logic [W-1:0]  fifo_dataIn;
    logic          fifo_read;
    logic [W-1:0]  fifo_dataOut;
    logic          fifo_full;
    logic          fifo_empty;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready = 1'b0;
    logic [2:0]    grant_id;
    logic [5:0]    count;
    logic          flag_err;

    fifo_req_sched #(.WIDTH(W), .DEPTH(D), .ADDWIDTH(5), .NREQ(NR), .BURST(BL)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_write(fifo_write), .fifo_dataIn(fifo_dataIn),
        .fifo_read(fifo_read), .fifo_dataOut(fifo_dataOut), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .grant_id(grant_id), .count(count), .flag_err(flag_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural FIFO the DUT drives.
    logic [W-1:0] mem [D];
    int  wp = 0, rp = 0, fcnt = 0;
    bit  force_bad = 1'b0;
    assign fifo_full    = (fcnt == D);
    assign fifo_empty   = (fcnt == 0) && !force_bad;
    assign fifo_dataOut = (fcnt > 0) ? mem[rp] : '0;

    // Reference model.
    bit  m_burst = 0;
    int  m_owner = 0, m_beats = 0, m_rr = 0, m_count = 0, m_gid = 0;
    bit  m_flag = 0;
    logic [W-1:0] mq[$];

    bit  d_lock, d_space, d_new;
    int  d_win;
    bit  e_wr, e_rd, e_ov;
    logic [W-1:0] e_din;
    logic [NR-1:0] e_rdy;
    bit  s_wr, s_rd, s_full, s_empty;
    logic [W-1:0] s_din;
    bit  chk_en = 0;

    bit  log_en = 0, wlog_en = 0;
    int  glog[$];
    int  wcount = 0, rcount = 0;

    always @(negedge clk) begin
        e_rdy   = '0;
        d_lock  = 0;
        d_space = 0;
        d_win   = -1;
        if (reset) begin
            d_space = (m_count != D);
            d_lock  = m_burst && req_valid[m_owner] && (m_beats < BL);
            for (int k = 0; k < NR; k++) begin
                if (d_win < 0 && req_valid[(m_rr + k) % NR]) d_win = (m_rr + k) % NR;
            end
            if (d_lock) begin
                if (d_space) e_rdy[m_owner] = 1'b1;
            end else if (d_space && d_win >= 0) begin
                e_rdy[d_win] = 1'b1;
            end
        end
        d_new = !d_lock && d_space && (d_win >= 0);
        e_wr  = |e_rdy;
        e_din = '0;
        for (int i = 0; i < NR; i++) if (e_rdy[i]) e_din = req_data[i*W +: W];
        e_ov = reset && (m_count != 0);
        e_rd = e_ov && out_ready;

        s_wr = fifo_write; s_rd = fifo_read; s_din = fifo_dataIn;
        s_full = fifo_full; s_empty = fifo_empty;

        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("fifo_write", 32'(fifo_write), 32'(e_wr));
            chk("fifo_dataIn", 32'(fifo_dataIn), 32'(e_din));
            chk("out_valid", 32'(out_valid), 32'(e_ov));
            chk("fifo_read", 32'(fifo_read), 32'(e_rd));
            chk("count", 32'(count), 32'(m_count));
            chk("grant_id", 32'(grant_id), 32'(m_gid));
            chk("flag_err", 32'(flag_err), 32'(m_flag));
            if (e_ov && mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
        end
        if (log_en && fifo_write) begin
            for (int i = 0; i < NR; i++) if (req_ready[i]) glog.push_back(i);
        end
        if (wlog_en) begin
            wcount += int'(fifo_write);
            rcount += int'(fifo_read);
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            m_burst <= 0; m_owner <= 0; m_beats <= 0; m_rr <= 0;
            m_count <= 0; m_gid <= 0; m_flag <= 0;
            mq.delete();
            chk_en <= 1;
            wp <= 0; rp <= 0; fcnt <= 0;
        end else begin
            if (s_full != (m_count == D) || s_empty != (m_count == 0)) m_flag <= 1;
            if (d_lock) begin
                if (d_space) m_beats <= m_beats + 1;
            end else if (d_new) begin
                m_burst <= 1; m_owner <= d_win; m_beats <= 1;
                m_rr <= (d_win + 1) % NR; m_gid <= d_win;
            end else begin
                m_burst <= 0;
            end
            if (e_wr) mq.push_back(e_din);
            if (e_rd) void'(mq.pop_front());
            m_count <= m_count + int'(e_wr) - int'(e_rd);

            if (s_wr && fcnt < D) begin
                mem[wp] <= s_din;
                wp <= (wp + 1) % D;
            end
            if (s_rd && fcnt > 0) rp <= (rp + 1) % D;
            fcnt <= fcnt + int'(s_wr && fcnt < D) - int'(s_rd && fcnt > 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; req_valid = '0; out_ready = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NR; i++) req_data[i*W +: W] = W'($urandom);
    endtask

    int exp_seq[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
    int exp_p5[3]   = '{2, 2, 3};

    initial begin
        reset = 1'b0;
        repeat (2) cyc();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);

        // Requester 1 alone for three beats.
        reset = 1'b1; req_valid = 4'b0010; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_data = '0;
            req_data[W +: W] = 21'h11 + 21'(k);
            cyc();
        end
        req_valid = '0;
        chk("p1_count", 32'(count), 32'd3);
        chk("p1_grant_id", 32'(grant_id), 32'd1);
        chk("p1_out_valid", 32'(out_valid), 32'd1);
        chk("p1_mem0", 32'(mem[0]), 32'h11);
        chk("p1_mem1", 32'(mem[1]), 32'h12);
        chk("p1_mem2", 32'(mem[2]), 32'h13);

        // All requesters valid, consumer always ready.
        do_reset();
        req_valid = 4'hf; out_ready = 1'b1;
        glog.delete(); log_en = 1;
        repeat (16) begin rand_data(); cyc(); end
        log_en = 0;
        chk("p2_nwrites", 32'(glog.size()), 32'd16);
        for (int i = 0; i < 16 && i < glog.size(); i++) chk("p2_grant_seq", 32'(glog[i]), 32'(exp_seq[i]));
        chk("p2_count", 32'(count), 32'd1);

        // Fill for 40 cycles with no reads.
        do_reset();
        req_valid = 4'hf; out_ready = 1'b0;
        wcount = 0; rcount = 0; wlog_en = 1;
        repeat (40) begin rand_data(); cyc(); end
        chk("p3_writes", 32'(wcount), 32'd32);
        chk("p3_count", 32'(count), 32'd32);
        chk("p3_full", 32'(fifo_full), 32'd1);
        chk("p3_flag_err", 32'(flag_err), 32'd0);
        chk("p3_req_ready", 32'(req_ready), 32'd0);

        // One read at full, then refill.
        wcount = 0; rcount = 0;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("p4_count_after_read", 32'(count), 32'd31);
        chk("p4_writes_at_full", 32'(wcount), 32'd0);
        chk("p4_reads", 32'(rcount), 32'd1);
        cyc();
        chk("p4_count_refill", 32'(count), 32'd32);
        chk("p4_refill_writes", 32'(wcount), 32'd1);
        wlog_en = 0;

        // Owner 2 drops after two beats while 3 waits.
        do_reset();
        glog.delete(); log_en = 1;
        req_valid = 4'b0100; rand_data(); cyc();
        req_valid = 4'b1100; rand_data(); cyc();
        req_valid = 4'b1000; rand_data(); cyc();
        log_en = 0; req_valid = '0;
        chk("p5_nwrites", 32'(glog.size()), 32'd3);
        for (int i = 0; i < 3 && i < glog.size(); i++) chk("p5_grant_seq", 32'(glog[i]), 32'(exp_p5[i]));
        chk("p5_grant_id", 32'(grant_id), 32'd3);
        chk("p5_count", 32'(count), 32'd3);

        // Random traffic with occasional reset.
        do_reset();
        repeat (3000) begin
            for (int i = 0; i < NR; i++) req_valid[i] = ($urandom_range(0, 3) != 0);
            rand_data();
            out_ready = ($urandom_range(0, 9) < 6);
            reset = ($urandom_range(0, 299) != 0);
            cyc();
        end

        // Flag mismatch is sticky until reset.
        do_reset();
        req_valid = '0;
        force_bad = 1'b1;
        cyc();
        force_bad = 1'b0;
        chk("p6_flag_set", 32'(flag_err), 32'd1);
        repeat (5) cyc();
        chk("p6_flag_sticky", 32'(flag_err), 32'd1);
        reset = 1'b0;
        cyc();
        chk("p6_flag_cleared", 32'(flag_err), 32'd0);
        reset = 1'b1;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
